// File: rtl/sar_ctrl_n.sv
// Successive-approximation ADC controller: sample phase, N_BITS binary-search
// trials driven by VCOMP, registered result with a one-cycle VALID strobe.
module sar_ctrl_n #(
  parameter int N_BITS        = 4,
  parameter int SAMPLE_CYCLES = 1,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic              VCOMP,
  output logic              SAR_RESET,
  output logic              SAMPLE_EN,
  output logic [N_BITS-1:0] BIT_EN,
  output logic [N_BITS-1:0] TRIAL,
  output logic [N_BITS-1:0] DOUT,
  output logic              VALID,
  output logic              BUSY
);

  localparam int IW = $clog2(N_BITS);
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [IW-1:0]     IDX_INIT  = IW'(N_BITS - 1);
  localparam logic [SW-1:0]     SCNT_INIT = SW'(SAMPLE_CYCLES - 1);
  localparam logic [N_BITS-1:0] MSB_ONE   = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CONV   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [SW-1:0]     scnt, scnt_nxt;
  logic [N_BITS-1:0] trial_nxt, bit_en_nxt, dout_nxt;
  logic              sar_reset_nxt, sample_en_nxt, valid_nxt, busy_nxt;
  logic              go_sample, go_idle;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    scnt_nxt   = scnt;
    trial_nxt  = TRIAL;
    bit_en_nxt = BIT_EN;
    dout_nxt   = DOUT;
    go_sample  = 1'b0;
    go_idle    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!ABORT && (START || CONTINUOUS)) go_sample = 1'b1;
      end
      S_SAMPLE: begin
        if (ABORT) begin
          go_idle = 1'b1;
        end else if (scnt == '0) begin
          state_nxt  = S_CONV;
          idx_nxt    = IDX_INIT;
          trial_nxt  = MSB_ONE;
          bit_en_nxt = MSB_ONE;
        end else begin
          scnt_nxt = scnt - 1'b1;
        end
      end
      S_CONV: begin
        if (ABORT) begin
          go_idle = 1'b1;
        end else begin
          trial_nxt[idx] = VCOMP;
          if (idx != '0) begin
            trial_nxt[idx - 1'b1] = 1'b1;
            idx_nxt    = idx - 1'b1;
            bit_en_nxt = BIT_EN >> 1;
          end else begin
            // LSB resolved here; the full code is captured directly into DOUT
            state_nxt  = S_DONE;
            dout_nxt   = trial_nxt;
            bit_en_nxt = '0;
          end
        end
      end
      S_DONE: begin
        if (!ABORT && (START || CONTINUOUS)) go_sample = 1'b1;
        else                                 go_idle   = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_sample) begin
      state_nxt  = S_SAMPLE;
      scnt_nxt   = SCNT_INIT;
      idx_nxt    = '0;
      trial_nxt  = '0;
      bit_en_nxt = '0;
    end
    if (go_idle) begin
      state_nxt  = S_IDLE;
      scnt_nxt   = '0;
      idx_nxt    = '0;
      trial_nxt  = '0;
      bit_en_nxt = '0;
    end

    // Status outputs are registered, so decode them from the next state
    sar_reset_nxt = (state_nxt == S_SAMPLE);
    sample_en_nxt = (state_nxt == S_SAMPLE);
    busy_nxt      = (state_nxt == S_SAMPLE) || (state_nxt == S_CONV);
    valid_nxt     = (state_nxt == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      idx       <= '0;
      scnt      <= '0;
      TRIAL     <= '0;
      BIT_EN    <= '0;
      DOUT      <= '0;
      SAR_RESET <= 1'b0;
      SAMPLE_EN <= 1'b0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      scnt      <= scnt_nxt;
      TRIAL     <= trial_nxt;
      BIT_EN    <= bit_en_nxt;
      DOUT      <= dout_nxt;
      SAR_RESET <= sar_reset_nxt;
      SAMPLE_EN <= sample_en_nxt;
      VALID     <= valid_nxt;
      BUSY      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sar_ctrl_n.sv
// Directed bench for sar_ctrl_n: four instances cover the base, long-sample,
// continuous and 8-bit configurations.
module tb_sar_ctrl_n;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: N=4 SC=1; b: N=4 SC=3; c: N=4 SC=1 continuous; d: N=8 SC=1
  logic       start_a, abort_a, vcomp_a, sr_a, se_a, valid_a, busy_a;
  logic [3:0] be_a, trial_a, dout_a;
  logic       start_b, abort_b, vcomp_b, sr_b, se_b, valid_b, busy_b;
  logic [3:0] be_b, trial_b, dout_b;
  logic       start_c, abort_c, vcomp_c, sr_c, se_c, valid_c, busy_c;
  logic [3:0] be_c, trial_c, dout_c;
  logic       start_d, abort_d, vcomp_d, sr_d, se_d, valid_d, busy_d;
  logic [7:0] be_d, trial_d, dout_d;

  sar_ctrl_n #(.N_BITS(4), .SAMPLE_CYCLES(1), .CONTINUOUS(1'b0)) u_a (
    .CLK(clk), .RESET_N(reset_n), .START(start_a), .ABORT(abort_a), .VCOMP(vcomp_a),
    .SAR_RESET(sr_a), .SAMPLE_EN(se_a), .BIT_EN(be_a), .TRIAL(trial_a),
    .DOUT(dout_a), .VALID(valid_a), .BUSY(busy_a));
  sar_ctrl_n #(.N_BITS(4), .SAMPLE_CYCLES(3), .CONTINUOUS(1'b0)) u_b (
    .CLK(clk), .RESET_N(reset_n), .START(start_b), .ABORT(abort_b), .VCOMP(vcomp_b),
    .SAR_RESET(sr_b), .SAMPLE_EN(se_b), .BIT_EN(be_b), .TRIAL(trial_b),
    .DOUT(dout_b), .VALID(valid_b), .BUSY(busy_b));
  sar_ctrl_n #(.N_BITS(4), .SAMPLE_CYCLES(1), .CONTINUOUS(1'b1)) u_c (
    .CLK(clk), .RESET_N(reset_n), .START(start_c), .ABORT(abort_c), .VCOMP(vcomp_c),
    .SAR_RESET(sr_c), .SAMPLE_EN(se_c), .BIT_EN(be_c), .TRIAL(trial_c),
    .DOUT(dout_c), .VALID(valid_c), .BUSY(busy_c));
  sar_ctrl_n #(.N_BITS(8), .SAMPLE_CYCLES(1), .CONTINUOUS(1'b0)) u_d (
    .CLK(clk), .RESET_N(reset_n), .START(start_d), .ABORT(abort_d), .VCOMP(vcomp_d),
    .SAR_RESET(sr_d), .SAMPLE_EN(se_d), .BIT_EN(be_d), .TRIAL(trial_d),
    .DOUT(dout_d), .VALID(valid_d), .BUSY(busy_d));

  localparam logic [3:0] EXP_BE    [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [3:0] EXP_TRIAL [4] = '{4'b1000, 4'b1100, 4'b1010, 4'b1011};

  // After tick returns we are 1 time unit into the cycle following the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one conversion on u_a, returns in the DONE cycle
  task automatic conv_a(input logic [3:0] pat);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      vcomp_a = pat[3-i];
      tick();
    end
    vcomp_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({sr_a, se_a, be_a, trial_a, dout_a, valid_a, busy_a} !== 17'd0) begin
      errors++;
      $display("FAIL reset_a got %h exp 0", {sr_a, se_a, be_a, trial_a, dout_a, valid_a, busy_a});
    end
    checks++;
    if ({sr_d, se_d, be_d, trial_d, dout_d, valid_d, busy_d} !== 29'd0) begin
      errors++;
      $display("FAIL reset_d got %h exp 0", {sr_d, se_d, be_d, trial_d, dout_d, valid_d, busy_d});
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_autostart busy got %b exp 0", busy_a);
    end
  endtask

  task automatic test_single();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if ({sr_a, se_a, busy_a, be_a, trial_a} !== {3'b111, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL single_sample got %b exp 11100000000", {sr_a, se_a, busy_a, be_a, trial_a});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (be_a !== EXP_BE[i] || trial_a !== EXP_TRIAL[i] || valid_a !== 1'b0) begin
        errors++;
        $display("FAIL single_conv%0d be/trial/valid got %b/%b/%b exp %b/%b/0",
                 i, be_a, trial_a, valid_a, EXP_BE[i], EXP_TRIAL[i]);
      end
      vcomp_a = (i != 1);
      tick();
    end
    vcomp_a = 1'b0;
    checks++;
    if ({valid_a, busy_a, be_a, dout_a, trial_a} !== {2'b10, 4'b0000, 4'b1011, 4'b1011}) begin
      errors++;
      $display("FAIL single_done valid/busy/be/dout/trial got %b exp 10000010111011",
               {valid_a, busy_a, be_a, dout_a, trial_a});
    end
    tick();
    checks++;
    if ({valid_a, busy_a, trial_a, dout_a} !== {2'b00, 4'b0000, 4'b1011}) begin
      errors++;
      $display("FAIL single_after valid/busy/trial/dout got %b exp 0000001011",
               {valid_a, busy_a, trial_a, dout_a});
    end
  endtask

  task automatic test_lsb();
    conv_a(4'b0001);
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 4'b0001) begin
      errors++;
      $display("FAIL lsb_0001 valid/dout got %b/%b exp 1/0001", valid_a, dout_a);
    end
    tick();
    conv_a(4'b0000);
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 4'b0000) begin
      errors++;
      $display("FAIL lsb_0000 valid/dout got %b/%b exp 1/0000", valid_a, dout_a);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start_a = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      vcomp_a = (c < 7);
      checks++;
      if (valid_a !== (c == 6 || c == 12) || se_a !== (c == 1 || c == 7)) begin
        errors++;
        $display("FAIL b2b_cycle%0d valid/sample_en got %b/%b exp %b/%b",
                 c, valid_a, se_a, (c == 6 || c == 12), (c == 1 || c == 7));
      end
      if (c == 6) begin
        checks++;
        if (dout_a !== 4'b1111) begin
          errors++;
          $display("FAIL b2b_dout1 got %b exp 1111", dout_a);
        end
      end
      if (c == 12) begin
        checks++;
        if (dout_a !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_dout2 got %b exp 0000", dout_a);
        end
        start_a = 1'b0;
      end
    end
    vcomp_a = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || se_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop busy/sample_en got %b/%b exp 0/0", busy_a, se_a);
    end
  endtask

  task automatic test_abort();
    int nv;
    conv_a(4'b0110);
    checks++;
    if (dout_a !== 4'b0110) begin
      errors++;
      $display("FAIL abort_setup dout got %b exp 0110", dout_a);
    end
    tick();
    // abort in the second CONV cycle
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++;
    if ({busy_a, trial_a, be_a, se_a, valid_a, dout_a} !== {1'b0, 4'b0000, 4'b0000, 2'b00, 4'b0110}) begin
      errors++;
      $display("FAIL abort_mid got %b exp 000000000000110",
               {busy_a, trial_a, be_a, se_a, valid_a, dout_a});
    end
    nv = 0;
    repeat (6) begin
      tick();
      nv += int'(valid_a);
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL abort_no_valid count got %0d exp 0", nv);
    end
    // abort coinciding with the LSB trial
    start_a = 1'b1;
    vcomp_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    checks++;
    if (be_a !== 4'b0001) begin
      errors++;
      $display("FAIL abort_last_pos bit_en got %b exp 0001", be_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    vcomp_a = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || dout_a !== 4'b0110 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_last valid/dout/busy got %b/%b/%b exp 0/0110/0", valid_a, dout_a, busy_a);
    end
    // abort beats start in IDLE
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    checks++;
    if (se_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle sample_en/busy got %b/%b exp 0/0", se_a, busy_a);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    checks++;
    if (busy_a !== 1'b1 || be_a !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_pre busy/bit_en got %b/%b exp 1/0100", busy_a, be_a);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({sr_a, se_a, be_a, trial_a, dout_a, valid_a, busy_a} !== 17'd0) begin
      errors++;
      $display("FAIL rstmid got %h exp 0", {sr_a, se_a, be_a, trial_a, dout_a, valid_a, busy_a});
    end
  endtask

  task automatic test_sample_len();
    start_b = 1'b1;
    vcomp_b = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start_b = 1'b0;
      checks++;
      if (se_b !== (c <= 3) || sr_b !== (c <= 3) || valid_b !== (c == 8)) begin
        errors++;
        $display("FAIL samplen_cycle%0d se/sr/valid got %b/%b/%b exp %b/%b/%b",
                 c, se_b, sr_b, valid_b, (c <= 3), (c <= 3), (c == 8));
      end
      if (c == 8) begin
        checks++;
        if (dout_b !== 4'b1111) begin
          errors++;
          $display("FAIL samplen_dout got %b exp 1111", dout_b);
        end
      end
    end
    vcomp_b = 1'b0;
  endtask

  task automatic test_continuous();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      vcomp_c = (c < 7);
      checks++;
      if (valid_c !== (c % 6 == 0) || busy_c !== (c % 6 != 0) || se_c !== (c == 1 || c == 7)) begin
        errors++;
        $display("FAIL cont_cycle%0d valid/busy/se got %b/%b/%b exp %b/%b/%b", c,
                 valid_c, busy_c, se_c, (c % 6 == 0), (c % 6 != 0), (c == 1 || c == 7));
      end
      if (c == 6 || c == 12) begin
        checks++;
        if (dout_c !== ((c == 6) ? 4'b1111 : 4'b0000)) begin
          errors++;
          $display("FAIL cont_dout%0d got %b exp %b", c, dout_c, (c == 6) ? 4'b1111 : 4'b0000);
        end
      end
    end
  endtask

  task automatic test_n8_ignored_start();
    logic [7:0] pat;
    int nv;
    pat = 8'b10110010;
    nv = 0;
    start_d = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      start_d = (c == 3 || c == 5 || c == 7);
      vcomp_d = (c >= 2 && c <= 9) ? pat[9-c] : 1'b0;
      nv += int'(valid_d);
      if (c == 2) begin
        checks++;
        if (be_d !== 8'h80 || trial_d !== 8'h80) begin
          errors++;
          $display("FAIL n8_first be/trial got %h/%h exp 80/80", be_d, trial_d);
        end
      end
      if (c == 10) begin
        checks++;
        if (valid_d !== 1'b1 || dout_d !== 8'hB2) begin
          errors++;
          $display("FAIL n8_done valid/dout got %b/%h exp 1/b2", valid_d, dout_d);
        end
      end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL n8_valid_count got %0d exp 1", nv);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    {start_a, abort_a, vcomp_a} = '0;
    {start_b, abort_b, vcomp_b} = '0;
    {start_c, abort_c, vcomp_c} = '0;
    {start_d, abort_d, vcomp_d} = '0;
    test_reset();
    test_single();
    test_lsb();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_sample_len();
    test_continuous();
    test_n8_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
